// File: rtl/lc3_pkg.sv
// LC-3 register-access sequencer shared definitions.
// Opcodes, FSM state encoding and the link register.
package lc3_pkg;

  localparam logic [3:0] OP_BR   = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_LD   = 4'h2;
  localparam logic [3:0] OP_ST   = 4'h3;
  localparam logic [3:0] OP_JSR  = 4'h4;
  localparam logic [3:0] OP_AND  = 4'h5;
  localparam logic [3:0] OP_LDR  = 4'h6;
  localparam logic [3:0] OP_STR  = 4'h7;
  localparam logic [3:0] OP_RTI  = 4'h8;
  localparam logic [3:0] OP_NOT  = 4'h9;
  localparam logic [3:0] OP_LDI  = 4'hA;
  localparam logic [3:0] OP_STI  = 4'hB;
  localparam logic [3:0] OP_JMP  = 4'hC;
  localparam logic [3:0] OP_RES  = 4'hD;
  localparam logic [3:0] OP_LEA  = 4'hE;
  localparam logic [3:0] OP_TRAP = 4'hF;

  localparam logic [2:0] R7 = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

endpackage

// File: rtl/lc3_reg_decode.sv
// LC-3 register field decoder.
// Maps an instruction word to register selects and write controls.
module lc3_reg_decode
  import lc3_pkg::*;
(
  input  logic [15:0] ir,
  output logic [2:0]  sr1,
  output logic [2:0]  sr2,
  output logic [2:0]  dr,
  output logic        imm_sel,
  output logic        writes,
  output logic        sets_cc
);

  logic [3:0] op;
  logic       unused_bits;

  assign op          = ir[15:12];
  assign unused_bits = ^ir[4:3];

  // Opcode-driven field extraction; unused selects stay 0
  always_comb begin
    sr1     = '0;
    sr2     = '0;
    dr      = '0;
    imm_sel = 1'b0;
    writes  = 1'b0;
    sets_cc = 1'b0;
    unique case (1'b1)
      (op == OP_ADD) || (op == OP_AND): begin
        dr      = ir[11:9];
        sr1     = ir[8:6];
        sr2     = ir[2:0];
        imm_sel = ir[5];
        writes  = 1'b1;
        sets_cc = 1'b1;
      end
      (op == OP_NOT): begin
        dr      = ir[11:9];
        sr1     = ir[8:6];
        writes  = 1'b1;
        sets_cc = 1'b1;
      end
      (op == OP_LD) || (op == OP_LDI) || (op == OP_LEA): begin
        dr      = ir[11:9];
        writes  = 1'b1;
        sets_cc = 1'b1;
      end
      (op == OP_LDR): begin
        dr      = ir[11:9];
        sr1     = ir[8:6];
        writes  = 1'b1;
        sets_cc = 1'b1;
      end
      (op == OP_ST) || (op == OP_STI): begin
        sr2 = ir[11:9];
      end
      (op == OP_STR): begin
        sr1 = ir[8:6];
        sr2 = ir[11:9];
      end
      (op == OP_JMP): begin
        sr1 = ir[8:6];
      end
      (op == OP_JSR): begin
        sr1    = ir[8:6];
        dr     = R7;
        writes = 1'b1;
      end
      (op == OP_TRAP): begin
        dr     = R7;
        writes = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: rtl/regfile_ctrl.sv
// LC-3 register-access sequencer top.
// Captures IR, pulses OP_START, then waits for the result or times out.
module regfile_ctrl
  import lc3_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 8
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [15:0] IR,
  input  logic        IR_VALID,
  output logic        IR_READY,
  output logic [2:0]  SR1_SEL,
  output logic [2:0]  SR2_SEL,
  output logic [2:0]  DR,
  output logic        LD_REG,
  output logic        LD_CC,
  output logic        IMM_SEL,
  output logic        OP_START,
  input  logic        RES_VALID,
  output logic        DONE,
  output logic        ERR,
  output logic        BUSY
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t             state_q, state_d;
  logic [15:0]        ir_q, ir_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               writes, sets_cc;

  lc3_reg_decode u_dec (
    .ir      (ir_q),
    .sr1     (SR1_SEL),
    .sr2     (SR2_SEL),
    .dr      (DR),
    .imm_sel (IMM_SEL),
    .writes  (writes),
    .sets_cc (sets_cc)
  );

  assign IR_READY = (state_q == ST_IDLE);
  assign BUSY     = (state_q != ST_IDLE);
  assign OP_START = (state_q == ST_READ);

  // Next-state, capture, wait counter and completion strobes
  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    cnt_d   = cnt_q;
    LD_REG  = 1'b0;
    LD_CC   = 1'b0;
    DONE    = 1'b0;
    ERR     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (IR_VALID) begin
          ir_d    = IR;
          state_d = ST_READ;
        end
      end
      ST_READ: begin
        cnt_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (RES_VALID) begin
          LD_REG  = writes;
          LD_CC   = sets_cc;
          DONE    = 1'b1;
          state_d = ST_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          ERR     = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, instruction and counter registers
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
      ir_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_regfile_ctrl.sv
// Randomized self-checking bench for regfile_ctrl.
// Transaction-level reference model of decode and timing.
module tb_regfile_ctrl;

  localparam int TIMEOUT = 16;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic [15:0] IR = '0;
  logic        IR_VALID = 1'b0;
  logic        IR_READY;
  logic [2:0]  SR1_SEL, SR2_SEL, DR;
  logic        LD_REG, LD_CC, IMM_SEL, OP_START;
  logic        RES_VALID = 1'b0;
  logic        DONE, ERR, BUSY;

  int n_chk  = 0;
  int n_pass = 0;
  int ld_cnt = 0;

  typedef struct packed {
    logic [2:0] sr1;
    logic [2:0] sr2;
    logic [2:0] dr;
    logic       imm;
    logic       wr;
    logic       cc;
  } exp_t;

  regfile_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(8)) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .IR        (IR),
    .IR_VALID  (IR_VALID),
    .IR_READY  (IR_READY),
    .SR1_SEL   (SR1_SEL),
    .SR2_SEL   (SR2_SEL),
    .DR        (DR),
    .LD_REG    (LD_REG),
    .LD_CC     (LD_CC),
    .IMM_SEL   (IMM_SEL),
    .OP_START  (OP_START),
    .RES_VALID (RES_VALID),
    .DONE      (DONE),
    .ERR       (ERR),
    .BUSY      (BUSY)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) if (LD_REG === 1'b1) ld_cnt++;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp)
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    else
      n_pass++;
  endtask

  function automatic exp_t ref_dec(input logic [15:0] ir);
    exp_t e;
    e = '0;
    case (ir[15:12])
      4'h1, 4'h5: begin
        e.dr = ir[11:9]; e.sr1 = ir[8:6]; e.sr2 = ir[2:0];
        e.imm = ir[5]; e.wr = 1; e.cc = 1;
      end
      4'h9: begin
        e.dr = ir[11:9]; e.sr1 = ir[8:6]; e.wr = 1; e.cc = 1;
      end
      4'h2, 4'hA, 4'hE: begin
        e.dr = ir[11:9]; e.wr = 1; e.cc = 1;
      end
      4'h6: begin
        e.dr = ir[11:9]; e.sr1 = ir[8:6]; e.wr = 1; e.cc = 1;
      end
      4'h3, 4'hB: e.sr2 = ir[11:9];
      4'h7: begin
        e.sr1 = ir[8:6]; e.sr2 = ir[11:9];
      end
      4'hC: e.sr1 = ir[8:6];
      4'h4: begin
        e.sr1 = ir[8:6]; e.dr = 3'd7; e.wr = 1;
      end
      4'hF: begin
        e.dr = 3'd7; e.wr = 1;
      end
      default: e = '0;
    endcase
    return e;
  endfunction

  function automatic logic [9:0] sel_of(input exp_t e);
    return {e.sr1, e.sr2, e.dr, e.imm};
  endfunction

  // d = WAIT cycle (1-based) carrying RES_VALID; 0 = never
  task automatic do_op(input logic [15:0] ir, input int d,
                       input bit pre, input bit hold,
                       input logic [15:0] nxt);
    exp_t e;
    int   base;
    bit   fin;
    bit   ok;
    e    = ref_dec(ir);
    base = ld_cnt;
    fin  = 0;
    ok   = 0;
    if (!pre) begin
      @(posedge CLK); #1;
      IR = ir;
      IR_VALID = 1'b1;
      @(negedge CLK);
    end
    chk("rdy_idle", IR_READY, 1);
    chk("busy_idle", BUSY, 0);
    @(posedge CLK); #1;
    if (hold) IR = nxt;
    else begin
      IR_VALID = 1'b0;
      IR = 16'($urandom);
    end
    @(negedge CLK);
    chk("op_start", OP_START, 1);
    chk("busy_read", BUSY, 1);
    chk("rdy_busy", IR_READY, 0);
    chk("sel_read", {SR1_SEL, SR2_SEL, DR, IMM_SEL}, sel_of(e));
    chk("ld_read", {LD_REG, LD_CC, DONE, ERR}, 0);
    for (int w = 1; w <= TIMEOUT && !fin; w++) begin
      @(posedge CLK); #1;
      RES_VALID = (w == d);
      @(negedge CLK);
      chk("op_start_wait", OP_START, 0);
      chk("busy_wait", BUSY, 1);
      chk("sel_wait", {SR1_SEL, SR2_SEL, DR, IMM_SEL}, sel_of(e));
      if (w == d) begin
        chk("done_strobes", {LD_REG, LD_CC, DONE, ERR},
            {e.wr, e.cc, 2'b10});
        fin = 1;
        ok  = 1;
      end else if (w == TIMEOUT) begin
        chk("timeout_strobes", {LD_REG, LD_CC, DONE, ERR}, 4'b0001);
        fin = 1;
      end else begin
        chk("wait_strobes", {LD_REG, LD_CC, DONE, ERR}, 0);
      end
    end
    @(posedge CLK); #1;
    RES_VALID = 1'b0;
    @(negedge CLK);
    chk("busy_after", BUSY, 0);
    chk("rdy_after", IR_READY, 1);
    chk("sel_hold", {SR1_SEL, SR2_SEL, DR, IMM_SEL}, sel_of(e));
    chk("ld_pulses", ld_cnt - base, (ok && e.wr) ? 1 : 0);
  endtask

  initial begin
    int base;
    #2;
    chk("rst_busy", BUSY, 0);
    chk("rst_rdy", IR_READY, 1);
    chk("rst_out", {SR1_SEL, SR2_SEL, DR, IMM_SEL, LD_REG, LD_CC,
                    OP_START, DONE, ERR}, 0);
    @(negedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;

    do_op(16'h1642, 1, 0, 0, 16'h0);
    do_op(16'h14BF, 5, 0, 0, 16'h0);
    do_op(16'h7980, 2, 0, 0, 16'h0);
    do_op(16'h4140, 3, 0, 1, 16'h1642);
    do_op(16'h1642, 1, 1, 0, 16'h0);
    do_op(16'h1642, 0, 0, 0, 16'h0);
    do_op(16'h1642, TIMEOUT, 0, 0, 16'h0);

    // Asynchronous reset in the middle of WAIT
    @(posedge CLK); #1;
    IR = 16'h1642;
    IR_VALID = 1'b1;
    @(posedge CLK); #1;
    IR_VALID = 1'b0;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    chk("busy_pre_rst", BUSY, 1);
    RES_VALID = 1'b1;
    base = ld_cnt;
    RST_N = 1'b0;
    #1;
    chk("arst_busy", BUSY, 0);
    chk("arst_rdy", IR_READY, 1);
    chk("arst_out", {SR1_SEL, SR2_SEL, DR, IMM_SEL, LD_REG, LD_CC,
                     OP_START, DONE, ERR}, 0);
    @(posedge CLK);
    @(posedge CLK);
    @(negedge CLK);
    chk("arst_no_ld", ld_cnt - base, 0);
    RST_N = 1'b1;
    RES_VALID = 1'b0;
    do_op(16'h1642, 1, 0, 0, 16'h0);

    for (int i = 0; i < 40; i++) begin
      do_op(16'($urandom), int'($urandom_range(0, TIMEOUT + 3)),
            0, 0, 16'h0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/regfile_ctrl.md
Name: regfile_ctrl

Overview:
Register-access sequencer for the LC-3 general-purpose register file. It accepts one instruction word at a time over a valid/ready handshake and decodes the register fields. It drives the register file's SR1_SEL/SR2_SEL/DR/LD_REG controls, starts the datapath operation, and waits for the result-valid strobe before committing the write-back. It sits between instruction fetch (IR) and the register file/ALU/memory datapath.

Parameters:
TIMEOUT, 16, max cycles spent in WAIT before the operation is aborted (legal range 2..255).
CNT_W, 8, width of the WAIT cycle counter; must satisfy 2^CNT_W >= TIMEOUT.

Ports:
CLK  input  1  system clock, rising edge.
RST_N  input  1  asynchronous, active-low reset.
IR  input  16  instruction word.
IR_VALID  input  1  IR is valid.
IR_READY  output  1  block can accept IR.
SR1_SEL  output  3  register file source-1 select.
SR2_SEL  output  3  register file source-2 select.
DR  output  3  register file destination select.
LD_REG  output  1  register file write enable; BUS is captured at this edge.
LD_CC  output  1  condition-code load enable.
IMM_SEL  output  1  1 = datapath uses imm5 instead of SR2.
OP_START  output  1  one-cycle pulse telling the datapath to begin.
RES_VALID  input  1  datapath result is present on BUS this cycle.
DONE  output  1  one-cycle completion pulse.
ERR  output  1  one-cycle timeout pulse.
BUSY  output  1  state != IDLE.

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-low: CLK and RST_N.
- States: IDLE, READ, WAIT.
- IDLE:
  - IR_READY=1.
  - When IR_VALID&IR_READY at an edge: capture IR into ir_q and go to READ.
  - IR_VALID while BUSY is ignored; no capture.
- READ:
  - OP_START=1 for exactly this cycle.
  - Clear the WAIT counter and go to WAIT.
- WAIT: the counter increments each cycle.
  - If RES_VALID: LD_REG=writes, LD_CC=sets_cc, DONE=1 (all combinational, same cycle); go to IDLE.
  - Else if counter==TIMEOUT-1: ERR=1, no LD_REG/LD_CC; go to IDLE.
  - RES_VALID in the timeout cycle counts as a normal completion; ERR stays 0.
- Selects: SR1_SEL/SR2_SEL/DR/IMM_SEL are decoded from ir_q. They are stable from READ until the next capture.
- Minimum latency: capture at edge k, OP_START in cycle k+1, write edge at end of cycle k+2, IR_READY again in cycle k+3.
- Decode by opcode ir_q[15:12]:
  - ADD 0001, AND 0101: DR=[11:9], SR1=[8:6], SR2=[2:0], IMM_SEL=[5]; writes, sets_cc.
  - NOT 1001: DR=[11:9], SR1=[8:6], IMM_SEL=0; writes, sets_cc.
  - LD 0010, LDI 1010, LEA 1110: DR=[11:9]; writes, sets_cc.
  - LDR 0110: DR=[11:9], SR1=[8:6]; writes, sets_cc.
  - ST 0011, STI 1011: SR2=[11:9] (store data); no write.
  - STR 0111: SR1=[8:6], SR2=[11:9]; no write.
  - JMP/RET 1100: SR1=[8:6]; no write.
  - JSR/JSRR 0100: SR1=[8:6], DR=7; writes, no cc.
  - TRAP 1111: DR=7; writes, no cc.
  - BR 0000, RTI 1000, reserved 1101: no write, no cc.
  - Unused select fields: 0.
- Reset (including mid-operation): state=IDLE, ir_q=0 (decodes as BR: no write).
  - Outputs while RST_N low: SR1_SEL, SR2_SEL, DR, IMM_SEL, LD_REG, LD_CC, OP_START, DONE, ERR, BUSY all 0; IR_READY=1 (IDLE).
  - An in-flight write is dropped; no LD_REG occurs.
- LD_REG is never asserted outside WAIT and is never asserted for more than one cycle per instruction.

Decomposition:
- Package lc3_pkg:
  - opcode localparams (OP_BR..OP_TRAP).
  - state encoding (IDLE/READ/WAIT).
  - R7 constant.
- Sub-module lc3_reg_decode: purely combinational.
  - Input: ir[15:0].
  - Outputs: sr1, sr2, dr, imm_sel, writes, sets_cc.
- regfile_ctrl holds the FSM, ir_q and the counter.

Test Plan:
- ADD R3,R1,R2, IR=16'h1642, RES_VALID in first WAIT cycle -> SR1_SEL=1, SR2_SEL=2, DR=3, IMM_SEL=0; LD_REG=LD_CC=DONE=1 for one cycle at k+2; IR_READY=1 at k+3.
- ADD R2,R2,#-1, IR=16'h14BF, RES_VALID after 5 WAIT cycles -> IMM_SEL=1, DR=2, SR1_SEL=2; single LD_REG in the 5th WAIT cycle; BUSY high 6 cycles.
- STR R4,R6,#0, IR=16'h7980 -> SR1_SEL=6, SR2_SEL=4, OP_START pulse; on RES_VALID DONE=1 with LD_REG=LD_CC=0.
- JSRR R5, IR=16'h4140 -> SR1_SEL=5, DR=7, LD_REG=1, LD_CC=0; a second IR_VALID held during BUSY is not captured until IDLE.
- TIMEOUT=16, RES_VALID never asserted -> ERR pulse in 16th WAIT cycle, no LD_REG/DONE, IDLE next. Repeat with RES_VALID in the 16th cycle -> DONE=1, LD_REG=1, ERR=0.
- Drop RST_N during WAIT -> BUSY/LD_REG/SR*_SEL/DR go 0 asynchronously. After release, IR=16'h1642 completes normally with one LD_REG.
